// File: rtl/can_host_pkg.sv
// ----------------------------------------------------------------------------
// can_host_pkg
// Shared definitions for the 8051-style register-port bus initiator:
//   - FSM state encodings (IDLE, ADDR, HOLD, STRB, REC, DONE)
//   - phase-counter width
//   - legal range for the per-phase cycle-count parameters
//   - a helper that range-checks one phase length
// ----------------------------------------------------------------------------
package can_host_pkg;

    // Phase timing runs on one 4-bit down-counter.
    localparam int unsigned PHASE_CNT_W = 4;

    // Every phase length parameter must fall in this range.
    localparam int unsigned PHASE_CYC_MIN = 1;
    localparam int unsigned PHASE_CYC_MAX = 15;

    // State encodings are kept as plain constants for compatibility with
    // older tools that consume this package.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_ADDR = 3'd1;
    localparam state_t ST_HOLD = 3'd2;
    localparam state_t ST_STRB = 3'd3;
    localparam state_t ST_REC  = 3'd4;
    localparam state_t ST_DONE = 3'd5;

    function automatic bit cyc_in_range(input int unsigned n);
        return (n >= PHASE_CYC_MIN) && (n <= PHASE_CYC_MAX);
    endfunction

endpackage

// File: rtl/can_host_phase_timer.sv
// ----------------------------------------------------------------------------
// can_host_phase_timer
// Loadable down-counter that times each bus phase. The FSM loads N-1 on
// phase entry and leaves the phase on the cycle where the count is zero.
// The counter parks at zero when not reloaded.
// Ports:
//   clk_i       clock (rising edge)
//   rst_ni      asynchronous active-low reset
//   load_i      load load_val_i on the next edge
//   load_val_i  value to load (phase length minus one)
//   value_o     current count
//   zero_o      count is zero: last cycle of the current phase
// ----------------------------------------------------------------------------
module can_host_phase_timer
    import can_host_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   load_i,
    input  logic [PHASE_CNT_W-1:0] load_val_i,
    output logic [PHASE_CNT_W-1:0] value_o,
    output logic                   zero_o
);

    // Load takes priority; otherwise count down and stop at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_o <= '0;
        end else if (load_i) begin
            value_o <= load_val_i;
        end else if (value_o != '0) begin
            value_o <= value_o - 1'b1;
        end
    end

    assign zero_o = (value_o == '0);

endmodule

// File: rtl/can_host_8051_master.sv
// ----------------------------------------------------------------------------
// can_host_8051_master
// Bus initiator for the CAN controller's 8051-style multiplexed register
// port. Takes one read/write command at a time on a valid/ready handshake,
// runs the ADDR/HOLD/STRB/REC bus sequence, and returns a one-cycle response.
//
// Optional feature macro: CAN_HOST_WRITE_VERIFY_EN
//   When defined, each write is followed by a readback of the same address.
//   The response then carries the readback data and verify_err_o.
//
// Ports:
//   clk_i, rst_ni                  clock / async active-low reset
//   cmd_valid_i, cmd_ready_o       command handshake
//   cmd_we_i, cmd_addr_i,
//   cmd_wdata_i                    command fields (1 = write)
//   rsp_valid_o, rsp_rdata_o,
//   verify_err_o                   one-cycle response
//   cs_o, ale_o, rd_o, wr_o        bus controls, active-high
//   port_0_o, port_0_oe_o,
//   port_0_i                       multiplexed address/data bus
// ----------------------------------------------------------------------------
module can_host_8051_master
    import can_host_pkg::*;
#(
    parameter int unsigned ALE_CYC  = 2,
    parameter int unsigned HOLD_CYC = 2,
    parameter int unsigned STRB_CYC = 4,
    parameter int unsigned REC_CYC  = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_we_i,
    input  logic [7:0] cmd_addr_i,
    input  logic [7:0] cmd_wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic       verify_err_o,
    output logic       cs_o,
    output logic       ale_o,
    output logic       rd_o,
    output logic       wr_o,
    output logic [7:0] port_0_o,
    output logic       port_0_oe_o,
    input  logic [7:0] port_0_i
);

    localparam bit PARAMS_OK = cyc_in_range(ALE_CYC) && cyc_in_range(HOLD_CYC) &&
                               cyc_in_range(STRB_CYC) && cyc_in_range(REC_CYC);

    localparam logic [PHASE_CNT_W-1:0] ALE_LD  = PHASE_CNT_W'(ALE_CYC - 1);
    localparam logic [PHASE_CNT_W-1:0] HOLD_LD = PHASE_CNT_W'(HOLD_CYC - 1);
    localparam logic [PHASE_CNT_W-1:0] STRB_LD = PHASE_CNT_W'(STRB_CYC - 1);
    localparam logic [PHASE_CNT_W-1:0] REC_LD  = PHASE_CNT_W'(REC_CYC - 1);

    state_t                   state_q, state_d;
    logic                     we_q, we_n;
    logic [7:0]               addr_q, addr_n;
    logic [7:0]               wdata_q, wdata_n;
    logic                     vfy_q, vfy_d;
    logic                     accept, capture, read_n;
    logic                     tmr_load;
    logic [PHASE_CNT_W-1:0]   tmr_load_val;
    logic [PHASE_CNT_W-1:0]   phase_cnt;
    logic                     phase_zero;

    assign accept  = cmd_valid_i && cmd_ready_o;
    assign capture = (state_q == ST_STRB) && phase_zero && (!we_q || vfy_q);

    // The values the command registers will hold next cycle. Bus outputs are
    // registered from these so that cs/ale rise on the cycle after accept.
    assign we_n    = accept ? cmd_we_i    : we_q;
    assign addr_n  = accept ? cmd_addr_i  : addr_q;
    assign wdata_n = accept ? cmd_wdata_i : wdata_q;

    can_host_phase_timer u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .value_o    (phase_cnt),
        .zero_o     (phase_zero)
    );

    // Next-state logic: each phase ends on the cycle the timer reads zero
    // and loads the length of the following phase.
    always_comb begin
        state_d      = state_q;
        vfy_d        = vfy_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d      = ST_ADDR;
                    vfy_d        = 1'b0;
                    tmr_load     = 1'b1;
                    tmr_load_val = ALE_LD;
                end
            end
            ST_ADDR: begin
                if (phase_zero) begin
                    state_d      = ST_HOLD;
                    tmr_load     = 1'b1;
                    tmr_load_val = HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (phase_zero) begin
                    state_d      = ST_STRB;
                    tmr_load     = 1'b1;
                    tmr_load_val = STRB_LD;
                end
            end
            ST_STRB: begin
                if (phase_zero) begin
                    state_d      = ST_REC;
                    tmr_load     = 1'b1;
                    tmr_load_val = REC_LD;
                end
            end
            ST_REC: begin
                if (phase_zero) begin
                    state_d = ST_DONE;
`ifdef CAN_HOST_WRITE_VERIFY_EN
                    // A write's recovery leads straight into the readback.
                    if (we_q && !vfy_q) begin
                        state_d      = ST_ADDR;
                        vfy_d        = 1'b1;
                        tmr_load     = 1'b1;
                        tmr_load_val = ALE_LD;
                    end
`endif
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The readback pass of a verified write is a read on the bus.
    assign read_n = !we_n || vfy_d;

    // State, command capture and all registered bus outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cmd_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            cs_o        <= 1'b0;
            ale_o       <= 1'b0;
            rd_o        <= 1'b0;
            wr_o        <= 1'b0;
            port_0_o    <= '0;
            port_0_oe_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_n;
            addr_q      <= addr_n;
            wdata_q     <= wdata_n;
            cmd_ready_o <= (state_d == ST_IDLE);
            rsp_valid_o <= (state_d == ST_DONE);
            cs_o        <= (state_d == ST_ADDR) || (state_d == ST_HOLD) ||
                           (state_d == ST_STRB) || (state_d == ST_REC);
            ale_o       <= (state_d == ST_ADDR);
            rd_o        <= (state_d == ST_STRB) && read_n;
            wr_o        <= (state_d == ST_STRB) && !read_n;
            if ((state_d == ST_ADDR) || (state_d == ST_HOLD)) begin
                port_0_o    <= addr_n;
                port_0_oe_o <= 1'b1;
            end else if (((state_d == ST_STRB) || (state_d == ST_REC)) && !read_n) begin
                port_0_o    <= wdata_n;
                port_0_oe_o <= 1'b1;
            end else begin
                port_0_o    <= '0;
                port_0_oe_o <= 1'b0;
            end
        end
    end

    // Read data is sampled on the edge that ends the last strobe cycle.
    // A plain write leaves the cleared value, so its response reads 0x00.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_rdata_o <= '0;
        end else if (accept) begin
            rsp_rdata_o <= '0;
        end else if (capture) begin
            rsp_rdata_o <= port_0_i;
        end
    end

`ifdef CAN_HOST_WRITE_VERIFY_EN
    // Readback flag and compare result for verified writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vfy_q        <= 1'b0;
            verify_err_o <= 1'b0;
        end else begin
            vfy_q <= vfy_d;
            if (accept) begin
                verify_err_o <= 1'b0;
            end else if (capture && vfy_q) begin
                verify_err_o <= (port_0_i != wdata_q);
            end
        end
    end
`else
    assign vfy_q        = 1'b0;
    assign verify_err_o = 1'b0;
`endif

    // Simulation-only sanity checks: phase lengths in range and the timer's
    // zero flag consistent with its count.
    always_ff @(posedge clk_i) begin
        assert (PARAMS_OK);
        assert (phase_zero == (phase_cnt == '0));
    end

endmodule
